// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access unit: FSM state encodings and default bus widths.
package mem_access_unit_pkg;

  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StWait   = 2'b01;
  localparam logic [1:0] StAccess = 2'b10;
  localparam logic [1:0] StDone   = 2'b11;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 16;

endpackage

// File: rtl/mem_ram_sp.sv
// Synchronous single-port word RAM with one-cycle read latency (read-first), block RAM style.
module mem_ram_sp #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access responder: latches a request, inserts WAIT_CYCLES wait states, accesses the RAM
// and pulses ack. Define MEM_ACCESS_BOUNDS_CHECK_EN to flag and block out-of-range addresses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] rd_word;
  logic              ram_we;
  logic              oob;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  assign oob = (addr_q >> DEPTH_LOG2) != '0;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |(addr_q >> DEPTH_LOG2);
  assign oob            = 1'b0;
`endif

  assign rd_word = oob ? '0 : ram_dout;

  // Reset gates the write so an access aborted at the ACCESS edge leaves memory untouched.
  assign ram_we = (state_q == StAccess) && we_q && !oob && !reset;

  mem_ram_sp #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .addr(addr_q[DEPTH_LOG2-1:0]),
    .din (wdata_q),
    .dout(ram_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StAccess;
        end
      end
      StAccess: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        if (!we_q) begin
          rdata_d = rd_word;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Read data is visible in the DONE cycle itself, then held in rdata_q.
  assign rdata = (state_q == StDone && !we_q) ? rd_word : rdata_q;
  assign ack   = (state_q == StDone);
  assign busy  = (state_q != StIdle);
  assign err   = ack && oob;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with one wait state, one with none.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset1, req1, we1;
  logic [15:0] addr1, wdata1, rdata1;
  logic        ack1, busy1, err1;
  logic        reset0, req0, we0;
  logic [15:0] addr0, wdata0, rdata0;
  logic        ack0, busy0, err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset1), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
  );

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the WAIT_CYCLES=1 instance; lat counts edges from acceptance to the ack cycle.
  task automatic do_access1(input logic w, input logic [15:0] a, input logic [15:0] d,
                            output int lat, output logic [15:0] rd, output logic er);
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    tick();
    lat  = 1;
    req1 = 1'b0;
    while (!ack1 && lat < 20) begin
      tick();
      lat++;
    end
    rd = rdata1;
    er = err1;
    tick();
  endtask

  task automatic test_reset();
    reset1 = 1'b1; reset0 = 1'b1;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (2) tick();
    reset1 = 1'b0; reset0 = 1'b0;
    tick();
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack1 got %b want 0", ack1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy1 got %b want 0", busy1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err1 got %b want 0", err1); end
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL rst_rdata1 got %h want 0", rdata1); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %b want 0", busy0); end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic er;
    do_access1(1'b1, 16'h0010, 16'hBEEF, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_lat got %0d want 3", lat); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL wr_rdata_hold got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", er); end
    do_access1(1'b0, 16'h0010, 16'h0000, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_lat got %0d want 3", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h want BEEF", rd); end
    checks++; if (rdata1 !== 16'hBEEF) begin errors++; $display("FAIL rd_held got %h want BEEF", rdata1); end
  endtask

  task automatic test_back_to_back();
    int nack = 0;
    int ack_at[3] = '{0, 0, 0};
    logic [15:0] rd2 = '0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'h1234;
    tick();
    we0 = 1'b0; wdata0 = 16'h0000;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (ack0) begin
        if (nack < 3) ack_at[nack] = n;
        if (nack == 1) rd2 = rdata0;
        nack++;
      end
    end
    req0 = 1'b0;
    tick();
    checks++; if (nack !== 3) begin errors++; $display("FAIL b2b_nack got %0d want 3", nack); end
    checks++; if (ack_at[0] !== 1) begin errors++; $display("FAIL b2b_ack0 got %0d want 1", ack_at[0]); end
    checks++; if (ack_at[1] !== 4) begin errors++; $display("FAIL b2b_ack1 got %0d want 4", ack_at[1]); end
    checks++; if (ack_at[2] !== 7) begin errors++; $display("FAIL b2b_ack2 got %0d want 7", ack_at[2]); end
    checks++; if (rd2 !== 16'h1234) begin errors++; $display("FAIL b2b_rdata got %h want 1234", rd2); end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] rd; logic er;
    logic [15:0] exp_rd;
    logic [15:0] exp_hi;
    logic        exp_err;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    exp_rd = 16'h1111; exp_hi = 16'h0000; exp_err = 1'b1;
`else
    exp_rd = 16'hA5A5; exp_hi = 16'hA5A5; exp_err = 1'b0;
`endif
    do_access1(1'b1, 16'h0005, 16'h1111, lat, rd, er);
    do_access1(1'b1, 16'h0405, 16'hA5A5, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oob_wr_lat got %0d want 3", lat); end
    checks++; if (er !== exp_err) begin errors++; $display("FAIL oob_wr_err got %b want %b", er, exp_err); end
    do_access1(1'b0, 16'h0005, 16'h0000, lat, rd, er);
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL wrap_rd got %h want %h", rd, exp_rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wrap_rd_err got %b want 0", er); end
    do_access1(1'b0, 16'h0405, 16'h0000, lat, rd, er);
    checks++; if (rd !== exp_hi) begin errors++; $display("FAIL oob_rd got %h want %h", rd, exp_hi); end
    checks++; if (er !== exp_err) begin errors++; $display("FAIL oob_rd_err got %b want %b", er, exp_err); end
  endtask

  task automatic test_reset_midop();
    int lat; int nack; logic [15:0] rd; logic er;
    do_access1(1'b1, 16'h0020, 16'h0BAD, lat, rd, er);
    do_access1(1'b1, 16'h0021, 16'h2222, lat, rd, er);
    do_access1(1'b1, 16'h0022, 16'h4444, lat, rd, er);
    // Reset while in WAIT
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'hFFFF;
    tick();
    req1 = 1'b0; reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rstw_busy got %b want 0", busy1); end
    nack = 0;
    for (int n = 0; n < 4; n++) begin
      if (ack1) nack++;
      tick();
    end
    checks++; if (nack !== 0) begin errors++; $display("FAIL rstw_noack got %0d want 0", nack); end
    do_access1(1'b0, 16'h0020, 16'h0000, lat, rd, er);
    checks++; if (rd !== 16'h0BAD) begin errors++; $display("FAIL rstw_mem got %h want 0BAD", rd); end
    // Reset at the ACCESS edge suppresses the write
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0021; wdata1 = 16'hFFFF;
    tick();
    req1 = 1'b0;
    tick();
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rsta_ack got %b want 0", ack1); end
    do_access1(1'b0, 16'h0021, 16'h0000, lat, rd, er);
    checks++; if (rd !== 16'h2222) begin errors++; $display("FAIL rsta_mem got %h want 2222", rd); end
    // Reset and request together: request is dropped
    reset1 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0022; wdata1 = 16'h3333;
    tick();
    reset1 = 1'b0; req1 = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rstreq_busy got %b want 0", busy1); end
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rstreq_busy2 got %b want 0", busy1); end
    do_access1(1'b0, 16'h0022, 16'h0000, lat, rd, er);
    checks++; if (rd !== 16'h4444) begin errors++; $display("FAIL rstreq_mem got %h want 4444", rd); end
  endtask

  task automatic test_busy_ignore();
    int lat; int nack; logic [15:0] rd; logic er;
    do_access1(1'b1, 16'h0031, 16'h0101, lat, rd, er);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0030; wdata1 = 16'hCAFE;
    tick();
    req1 = 1'b0; addr1 = 16'h0031; wdata1 = 16'hDEAD;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL bsy_busy got %b want 1", busy1); end
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    nack = 0;
    for (int n = 0; n < 6; n++) begin
      if (ack1) nack++;
      tick();
    end
    checks++; if (nack !== 1) begin errors++; $display("FAIL bsy_nack got %0d want 1", nack); end
    do_access1(1'b0, 16'h0030, 16'h0000, lat, rd, er);
    checks++; if (rd !== 16'hCAFE) begin errors++; $display("FAIL bsy_orig got %h want CAFE", rd); end
    do_access1(1'b0, 16'h0031, 16'h0000, lat, rd, er);
    checks++; if (rd !== 16'h0101) begin errors++; $display("FAIL bsy_other got %h want 0101", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
